// File: rtl/bsg_chip_wh_link_gate_pkg.sv
// Shared types for the wormhole link gate: framing states, header layout
// macro and the drop counter width.
`ifndef BSG_CHIP_WH_LINK_GATE_PKG_SV
`define BSG_CHIP_WH_LINK_GATE_PKG_SV

// Low bits of a wormhole header flit: length above the destination cord.
`define DECLARE_BSG_CHIP_WH_HDR_S(cord_width, len_width) \
  typedef struct packed { \
    logic [len_width-1:0]  len; \
    logic [cord_width-1:0] cord; \
  } bsg_chip_wh_hdr_s

package bsg_chip_wh_link_gate_pkg;

  typedef enum logic [1:0] {
    e_header,
    e_body,
    e_drop
  } state_e;

  localparam int unsigned drop_cnt_width_lp = 16;

endpackage

`endif

// File: rtl/bsg_chip_wh_link_gate_fifo.sv
// Two-pointer FIFO with async active-low reset, full/empty flags and no
// bypass path; the head entry is presented combinationally.
module bsg_chip_wh_link_gate_fifo #(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [width_p-1:0] wdata,
    input  logic               pop,
    output logic [width_p-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned ptr_w = $clog2(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w:0]     wptr;
    logic [ptr_w:0]     rptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[ptr_w-1:0]] <= wdata;
        end
    end

    // Pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (ptr_w + 1)'(1);
            if (do_pop)  rptr <= rptr + (ptr_w + 1)'(1);
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[ptr_w] != rptr[ptr_w]) &&
                   (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]);
    assign rdata = mem[rptr[ptr_w-1:0]];

endmodule

// File: rtl/bsg_chip_wh_link_gate.sv
// Wormhole flit buffer and packet-boundary gate feeding links_i slot 2.
// The gate opens/closes only between packets; closed packets are held
// (drop_p=0) or discarded and counted (drop_p=1).
// Optional macro BSG_CHIP_WH_LINK_GATE_STATS_EN adds pkt_cnt_o/flit_cnt_o.
module bsg_chip_wh_link_gate
  import bsg_chip_wh_link_gate_pkg::*;
#(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned cord_width_p = 7,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned els_p        = 4,
  parameter int unsigned drop_p       = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic                         v_i,
  input  logic [flit_width_p-1:0]      data_i,
  output logic                         ready_and_o,
  output logic                         v_o,
  output logic [flit_width_p-1:0]      data_o,
  input  logic                         ready_and_i,
  output logic                         idle_o,
  output logic [drop_cnt_width_lp-1:0] drop_cnt_o
`ifdef BSG_CHIP_WH_LINK_GATE_STATS_EN
  ,
  output logic [31:0]                  pkt_cnt_o,
  output logic [31:0]                  flit_cnt_o
`endif
);

  `DECLARE_BSG_CHIP_WH_HDR_S(cord_width_p, len_width_p);

  localparam int unsigned hdr_w = cord_width_p + len_width_p;
  localparam logic [drop_cnt_width_lp-1:0] drop_max = '1;

  state_e                  state, state_n;
  logic [len_width_p-1:0]  remaining, remaining_n;
  logic                    up;
  logic                    full, empty, push, pop, drop_hdr;
  logic [flit_width_p-1:0] head;
  bsg_chip_wh_hdr_s        hdr;

  assign push        = v_i & ready_and_o;
  assign ready_and_o = up & ~full;
  assign hdr         = head[hdr_w-1:0];
  assign data_o      = {head[flit_width_p-1:hdr_w], hdr};
  assign idle_o      = empty & (state == e_header);

  bsg_chip_wh_link_gate_fifo #(
    .width_p (flit_width_p),
    .els_p   (els_p)
  ) fifo (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .push  (push),
    .wdata (data_i),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Framing decisions on the FIFO head: forward, hold or discard.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    v_o         = 1'b0;
    pop         = 1'b0;
    drop_hdr    = 1'b0;
    unique case (state)
      e_header: begin
        if (!empty) begin
          if (en_i) begin
            v_o = 1'b1;
            if (ready_and_i) begin
              pop = 1'b1;
              if (hdr.len != '0) begin
                state_n     = e_body;
                remaining_n = hdr.len;
              end
            end
          end else if (drop_p != 0) begin
            pop      = 1'b1;
            drop_hdr = 1'b1;
            if (hdr.len != '0) begin
              state_n     = e_drop;
              remaining_n = hdr.len;
            end
          end
        end
      end
      e_body: begin
        v_o = ~empty;
        if (!empty && ready_and_i) begin
          pop         = 1'b1;
          remaining_n = remaining - len_width_p'(1);
          if (remaining == len_width_p'(1)) state_n = e_header;
        end
      end
      e_drop: begin
        if (!empty) begin
          pop         = 1'b1;
          remaining_n = remaining - len_width_p'(1);
          if (remaining == len_width_p'(1)) state_n = e_header;
        end
      end
      default: state_n = e_header;
    endcase
  end

  // Framing state, body count and the post-reset ready enable.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= e_header;
      remaining <= '0;
      up        <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      up        <= 1'b1;
    end
  end

  // Saturating count of discarded packets.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_cnt_o <= '0;
    end else if (drop_hdr && drop_cnt_o != drop_max) begin
      drop_cnt_o <= drop_cnt_o + drop_cnt_width_lp'(1);
    end
  end

`ifdef BSG_CHIP_WH_LINK_GATE_STATS_EN
  logic fwd;
  assign fwd = v_o & ready_and_i;

  // Forwarded packet and flit counters, wrapping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_cnt_o  <= '0;
      flit_cnt_o <= '0;
    end else begin
      if (fwd && state == e_header) pkt_cnt_o <= pkt_cnt_o + 32'd1;
      if (fwd) flit_cnt_o <= flit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_chip_wh_link_gate.sv
// Bench for bsg_chip_wh_link_gate: a hold instance (drop_p=0) and a drop
// instance (drop_p=1) checked against a queue-based packet model.
module tb_bsg_chip_wh_link_gate;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vin   [2];
    logic [63:0] din   [2];
    logic        en    [2];
    logic        rdy   [2];
    logic        rdy_o [2];
    logic        v_o   [2];
    logic [63:0] dout  [2];
    logic        idle  [2];
    logic [15:0] dcnt  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_chip_wh_link_gate #(
        .flit_width_p(64), .cord_width_p(7), .len_width_p(4), .els_p(4), .drop_p(0)
    ) dut_hold (
        .clk_i(clk), .reset_n_i(rstn), .en_i(en[0]), .v_i(vin[0]), .data_i(din[0]),
        .ready_and_o(rdy_o[0]), .v_o(v_o[0]), .data_o(dout[0]), .ready_and_i(rdy[0]),
        .idle_o(idle[0]), .drop_cnt_o(dcnt[0])
    );

    bsg_chip_wh_link_gate #(
        .flit_width_p(64), .cord_width_p(7), .len_width_p(4), .els_p(4), .drop_p(1)
    ) dut_drop (
        .clk_i(clk), .reset_n_i(rstn), .en_i(en[1]), .v_i(vin[1]), .data_i(din[1]),
        .ready_and_o(rdy_o[1]), .v_o(v_o[1]), .data_o(dout[1]), .ready_and_i(rdy[1]),
        .idle_o(idle[1]), .drop_cnt_o(dcnt[1])
    );

    // Model: list of buffered flits plus packet progress (0 between packets,
    // 1 forwarding a packet, 2 discarding a packet) and flits still owed.
    logic [63:0] mq [2][8];
    int mcnt  [2] = '{0, 0};
    int mup   [2] = '{0, 0};
    int mmode [2] = '{0, 0};
    int mleft [2] = '{0, 0};
    int mdrop [2] = '{0, 0};

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input int len, input logic [52:0] tag);
        logic [3:0] l;
        l = 4'(len);
        return {tag, l, 7'h15};
    endfunction

    function automatic logic e_ready(input int k);
        return (mup[k] != 0) && (mcnt[k] < 4);
    endfunction

    function automatic logic e_valid(input int k);
        if (mcnt[k] == 0) return 1'b0;
        if (mmode[k] == 1) return 1'b1;
        if (mmode[k] == 0) return en[k];
        return 1'b0;
    endfunction

    function automatic logic e_pop(input int k);
        if (mcnt[k] == 0) return 1'b0;
        if (mmode[k] == 1) return rdy[k];
        if (mmode[k] == 2) return 1'b1;
        if (en[k]) return rdy[k];
        return (k == 1);
    endfunction

    // Model update on each clock edge, cleared by reset.
    initial forever begin
        @(posedge clk or negedge rstn);
        for (int k = 0; k < 2; k++) begin
            logic        p;
            logic        s;
            logic [63:0] f;
            int          len;
            if (!rstn) begin
                mcnt[k] = 0; mup[k] = 0; mmode[k] = 0; mleft[k] = 0; mdrop[k] = 0;
            end else begin
                p = e_pop(k);
                s = vin[k] && e_ready(k);
                if (p) begin
                    f = mq[k][0];
                    for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
                    mcnt[k]--;
                    if (mmode[k] == 0) begin
                        len = int'(f[10:7]);
                        if (!en[k] && mdrop[k] < 65535) mdrop[k]++;
                        if (len != 0) begin
                            mmode[k] = en[k] ? 1 : 2;
                            mleft[k] = len;
                        end
                    end else begin
                        mleft[k]--;
                        if (mleft[k] == 0) mmode[k] = 0;
                    end
                end
                if (s) begin
                    mq[k][mcnt[k]] = din[k];
                    mcnt[k]++;
                end
                mup[k] = 1;
            end
        end
    end

    // Every cycle, both instances against the model.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("ready_and_o", k, rdy_o[k], e_ready(k));
            check("v_o", k, v_o[k], e_valid(k));
            check("idle_o", k, idle[k], mcnt[k] == 0 && mmode[k] == 0);
            check("drop_cnt_o", k, dcnt[k], mdrop[k]);
            if (e_valid(k)) check("data_o", k, dout[k], mq[k][0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [63:0] d);
        logic done;
        done = 1'b0;
        vin[k] = 1'b1;
        din[k] = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rdy_o[k] === 1'b1) done = 1'b1;
            tick();
        end
        vin[k] = 1'b0;
        check("push_accepted", k, done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; din[k] = '0; en[k] = 1'b0; rdy[k] = 1'b0;
        end
        repeat (2) tick();
        check("idle_in_reset", 0, idle[0], 1'b1);
        check("ready_in_reset", 0, rdy_o[0], 1'b0);
        check("v_in_reset", 0, v_o[0], 1'b0);
        rstn = 1'b1;
        #2 check("ready_before_edge", 0, rdy_o[0], 1'b0);
        tick();
        check("ready_after_edge", 0, rdy_o[0], 1'b1);

        // Header len=2 plus two bodies, gate open.
        en[0] = 1'b1; rdy[0] = 1'b1;
        check("v_before_push", 0, v_o[0], 1'b0);
        push(0, hdr(2, 53'h1));
        check("v_one_after_push", 0, v_o[0], 1'b1);
        check("data_header", 0, dout[0], hdr(2, 53'h1));
        push(0, 64'hB1);
        push(0, 64'hB2);
        check("data_last_body", 0, dout[0], 64'hB2);
        tick();
        check("idle_after_pkt", 0, idle[0], 1'b1);

        // Closed gate holds a len=1 packet, then releases it.
        en[0] = 1'b0;
        push(0, hdr(1, 53'h2));
        push(0, 64'hC1);
        tick(); tick();
        check("held_v", 0, v_o[0], 1'b0);
        check("held_not_idle", 0, idle[0], 1'b0);
        check("held_ready", 0, rdy_o[0], 1'b1);
        en[0] = 1'b1;
        #1 check("release_v", 0, v_o[0], 1'b1);
        check("release_hdr", 0, dout[0], hdr(1, 53'h2));
        tick();
        check("release_body_v", 0, v_o[0], 1'b1);
        check("release_body", 0, dout[0], 64'hC1);
        tick();
        check("release_done", 0, idle[0], 1'b1);

        // Gate closes mid-packet: body still flows, next header held.
        push(0, hdr(3, 53'h3));
        push(0, 64'hD1);
        en[0] = 1'b0;
        push(0, 64'hD2);
        push(0, 64'hD3);
        push(0, hdr(0, 53'h4));
        repeat (3) tick();
        check("next_hdr_held_v", 0, v_o[0], 1'b0);
        check("next_hdr_held_idle", 0, idle[0], 1'b0);
        check("next_hdr_at_head", 0, dout[0], hdr(0, 53'h4));
        en[0] = 1'b1;
        tick();
        check("next_hdr_gone", 0, idle[0], 1'b1);

        // Drop instance: three closed packets discarded.
        en[1] = 1'b0; rdy[1] = 1'b1;
        push(1, hdr(0, 53'h5));
        push(1, hdr(2, 53'h6));
        push(1, 64'hE1);
        push(1, 64'hE2);
        push(1, hdr(0, 53'h7));
        repeat (3) tick();
        check("drop_count", 1, dcnt[1], 16'd3);
        check("drop_idle", 1, idle[1], 1'b1);
        en[1] = 1'b1;
        push(1, hdr(0, 53'h8));
        check("drop_inst_fwd_v", 1, v_o[1], 1'b1);
        check("drop_inst_fwd_d", 1, dout[1], hdr(0, 53'h8));
        tick();
        check("drop_inst_idle", 1, idle[1], 1'b1);

        // Backpressure: fill, then the fifth is accepted after the first pop.
        rdy[0] = 1'b0;
        push(0, hdr(4, 53'h9));
        push(0, 64'hF1);
        push(0, 64'hF2);
        push(0, 64'hF3);
        check("full_ready_low", 0, rdy_o[0], 1'b0);
        vin[0] = 1'b1; din[0] = 64'hF4;
        tick();
        check("still_full", 0, rdy_o[0], 1'b0);
        rdy[0] = 1'b1;
        tick();
        check("ready_after_pop", 0, rdy_o[0], 1'b1);
        check("head_after_pop", 0, dout[0], 64'hF1);
        tick();
        vin[0] = 1'b0;
        repeat (4) tick();
        check("bp_drained", 0, idle[0], 1'b1);

        // Reset mid-body with remaining=2 and three flits buffered.
        rdy[0] = 1'b0;
        push(0, hdr(3, 53'hA));
        push(0, 64'hA1);
        push(0, 64'hA2);
        push(0, 64'hA3);
        rdy[0] = 1'b1; vin[0] = 1'b1; din[0] = hdr(0, 53'hB);
        tick(); tick();
        vin[0] = 1'b0; rdy[0] = 1'b0;
        check("mid_body_v", 0, v_o[0], 1'b1);
        check("mid_body_head", 0, dout[0], 64'hA2);
        #2 rstn = 1'b0;
        #1 check("async_v", 0, v_o[0], 1'b0);
        check("async_ready", 0, rdy_o[0], 1'b0);
        check("async_idle", 0, idle[0], 1'b1);
        tick(); tick();
        rstn = 1'b1;
        tick();
        check("post_reset_idle", 0, idle[0], 1'b1);
        rdy[0] = 1'b1;
        push(0, hdr(0, 53'hC));
        check("post_reset_hdr_v", 0, v_o[0], 1'b1);
        check("post_reset_hdr_d", 0, dout[0], hdr(0, 53'hC));
        tick();
        check("post_reset_hdr_done", 0, idle[0], 1'b1);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
